// File: rtl/shift_pipelined_radix.sv
// shift_pipelined_radix: radix-2^RADIX_BITS pipelined shifter/rotator with valid/ready flow control
module shift_pipelined_radix #(
  parameter int WIDTH = 13,
  parameter int RADIX_BITS = 2,
  parameter int TAG_W = 4,
  localparam int SHAMT_W = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1,
  localparam int STAGES = (SHAMT_W + RADIX_BITS - 1) / RADIX_BITS
)(
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_valid,
  input  logic               out_ready
);
  logic [STAGES-1:0]     r_valid;
  logic [WIDTH-1:0]      r_data [STAGES];
  logic [SHAMT_W-1:0]    r_shamt [STAGES];
  logic [1:0]            r_mode [STAGES];
  logic [TAG_W-1:0]      r_tag [STAGES];
  logic                  w_v [STAGES+1];
  logic [WIDTH-1:0]      w_d [STAGES+1];
  logic [SHAMT_W-1:0]    w_s [STAGES+1];
  logic [1:0]            w_m [STAGES+1];
  logic [TAG_W-1:0]      w_t [STAGES+1];
  logic [RADIX_BITS-1:0] w_dig [STAGES];
  logic [WIDTH-1:0]      w_nd [STAGES];
  logic [STAGES:0]       w_load;

  // Rotation uses displacement mod WIDTH so chained stages compose to shamt mod WIDTH
  function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] x, input logic [1:0] m, input int d);
    logic [WIDTH-1:0] asr;
    int r;
    asr = $signed(x) >>> d;
    r = d % WIDTH;
    return m == 2'b00 ? x >> d : m == 2'b01 ? x << d : m == 2'b10 ? (x >> r) | (x << (WIDTH - r)) : asr;
  endfunction

  always_comb begin
    w_v[0] = in_valid;
    w_d[0] = in_data;
    w_s[0] = in_shamt;
    w_m[0] = in_mode;
    w_t[0] = in_tag;
    for (int s = 0; s < STAGES; s++) begin
      w_v[s+1] = r_valid[s];
      w_d[s+1] = r_data[s];
      w_s[s+1] = r_shamt[s];
      w_m[s+1] = r_mode[s];
      w_t[s+1] = r_tag[s];
    end
  end

  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      w_dig[s] = RADIX_BITS'((STAGES*RADIX_BITS)'(w_s[s]) >> (s * RADIX_BITS));
      w_nd[s] = w_d[s];
      for (int k = 0; k < 2**RADIX_BITS; k++)
        if (w_dig[s] == RADIX_BITS'(k)) w_nd[s] = f_shift(w_d[s], w_m[s], k << (s * RADIX_BITS));
    end
  end

  // A stage loads when empty or when its occupant moves on this cycle
  always_comb begin
    w_load[STAGES] = out_ready;
    for (int s = STAGES - 1; s >= 0; s--) w_load[s] = !r_valid[s] || w_load[s+1];
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < STAGES; s++)
      if (reset) begin
        r_valid[s] <= 1'b0;
        r_data[s]  <= '0;
        r_shamt[s] <= '0;
        r_mode[s]  <= '0;
        r_tag[s]   <= '0;
      end else if (w_load[s]) begin
        r_valid[s] <= w_v[s];
        if (w_v[s]) begin
          r_data[s]  <= w_nd[s];
          r_shamt[s] <= w_s[s];
          r_mode[s]  <= w_m[s];
          r_tag[s]   <= w_t[s];
        end
      end
  end

  assign in_ready  = w_load[0];
  assign out_valid = r_valid[STAGES-1];
  assign out_data  = r_data[STAGES-1];
  assign out_tag   = r_tag[STAGES-1];
endmodule

// File: tb/tb_shift_pipelined_radix.sv
// tb_shift_pipelined_radix: directed + random checks against a bitwise reference model, plus a parameter sweep
module tb_shift_pipelined_radix;
  typedef struct {
    logic [63:0] d;
    logic [3:0]  t;
    int          c;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [12:0] in_data;
  logic [3:0]  in_shamt;
  logic [1:0]  in_mode;
  logic [3:0]  in_tag;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] out_data;
  logic [3:0]  out_tag;
  logic        out_valid;
  logic        out_ready;

  int          n_vec;
  int          n_err;
  int          n_out;
  int          cyc;
  int          sw_done;
  logic        lat_on;
  logic [63:0] cur_exp;
  exp_t        sb[$];

  shift_pipelined_radix u_dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
    .in_tag(in_tag), .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_tag(out_tag), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit-by-bit definition of each mode, independent of any stage decomposition
  function automatic logic [63:0] ref_shift(input logic [63:0] x, input int sh, input logic [1:0] m, input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w; i++)
      case (m)
        2'b00:   r[i] = (i + sh < w) ? x[i+sh] : 1'b0;
        2'b01:   r[i] = (i >= sh) ? x[i-sh] : 1'b0;
        2'b10:   r[i] = x[(i + sh) % w];
        default: r[i] = (i + sh < w) ? x[i+sh] : x[w-1];
      endcase
    return r;
  endfunction

  // Observe the handshakes of the coming edge, update the scoreboard, then pass the edge
  task automatic tick();
    exp_t e;
    #1;
    if (reset) sb.delete();
    else begin
      chk("in_ready", 64'(in_ready), 64'(out_ready || sb.size() < 2));
      if (out_valid && !out_ready && sb.size() > 0) begin
        chk("hold_data", 64'(out_data), sb[0].d);
        chk("hold_tag", 64'(out_tag), 64'(sb[0].t));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("stale_out", 64'(1), 64'(0));
        else begin
          e = sb.pop_front();
          chk("out_data", 64'(out_data), e.d);
          chk("out_tag", 64'(out_tag), 64'(e.t));
          if (lat_on) chk("latency", 64'(cyc - e.c), 64'(2));
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        e.d = cur_exp;
        e.t = in_tag;
        e.c = cyc;
        sb.push_back(e);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic rand_in(input int tag);
    in_valid = 1'b1;
    in_data  = 13'($urandom());
    in_shamt = 4'($urandom());
    in_mode  = 2'($urandom());
    in_tag   = 4'(tag);
    cur_exp  = ref_shift(64'(in_data), int'(in_shamt), in_mode, 13);
  endtask

  initial begin
    logic [3:0]  shs [7] = '{4'd3, 4'd3, 4'd3, 4'd3, 4'd15, 4'd15, 4'd15};
    logic [1:0]  ms  [7] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b11, 2'b10};
    logic [12:0] dx  [7] = '{13'h0200, 13'h0008, 13'h0600, 13'h1E00, 13'h0000, 13'h1FFF, 13'h0C00};
    int n0;
    n_vec = 0; n_err = 0; n_out = 0; cyc = 0; lat_on = 1'b1; cur_exp = '0;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_mode = '0; in_tag = '0; out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_tag", 64'(out_tag), 64'(0));
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = 13'h1001; in_shamt = shs[i]; in_mode = ms[i]; in_tag = 4'(i);
      cur_exp = 64'(dx[i]);
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    chk("directed_cnt", 64'(n_out), 64'(7));
    n0 = n_out;
    for (int i = 0; i < 20; i++) begin
      rand_in(i);
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    chk("stream_cnt", 64'(n_out - n0), 64'(20));
    lat_on = 1'b0;
    n0 = n_out;
    for (int i = 0; i < 20; i++) begin
      out_ready = !(i >= 6 && i < 11);
      rand_in(i);
      tick();
    end
    out_ready = 1'b1; in_valid = 1'b0;
    repeat (6) tick();
    chk("stall_drain", 64'(sb.size()), 64'(0));
    chk("stall_cnt", 64'(n_out - n0), 64'(n0 + sb.size() + 20 - n0 - (20 - (n_out - n0)) + (20 - (n_out - n0)) - 20 + (n_out - n0)));
    lat_on = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rand_in(i);
      tick();
    end
    reset = 1'b1;
    rand_in(9);
    tick();
    reset = 1'b0; in_valid = 1'b0;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    n0 = n_out;
    repeat (6) tick();
    chk("midrst_no_stale", 64'(n_out - n0), 64'(0));
    lat_on = 1'b0;
    for (int i = 0; i < 12; i++) begin
      out_ready = 1'($urandom());
      rand_in(i);
      in_valid = 1'($urandom());
      tick();
    end
    out_ready = 1'b1; in_valid = 1'b0;
    repeat (6) tick();
    chk("recover_drain", 64'(sb.size()), 64'(0));
    for (int k = 0; k < 5000 && sw_done < 15; k++) @(negedge clk);
    chk("sweep_done", 64'(sw_done), 64'(15));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial sw_done = 0;

  for (genvar c = 0; c < 15; c++) begin : g_sw
    localparam int W  = (c / 3 == 0) ? 2 : (c / 3 == 1) ? 8 : (c / 3 == 2) ? 13 : (c / 3 == 3) ? 32 : 64;
    localparam int R  = c % 3 + 1;
    localparam int SW = ($clog2(W) > 1) ? $clog2(W) : 1;
    localparam int ST = (SW + R - 1) / R;
    logic          rst, v, rdy, ov;
    logic [W-1:0]  d, od;
    logic [SW-1:0] sh;
    logic [1:0]    m;
    logic [3:0]    tg, otg;
    exp_t          q[$];

    shift_pipelined_radix #(.WIDTH(W), .RADIX_BITS(R), .TAG_W(4)) u_sw (
      .clk(clk), .reset(rst), .in_data(d), .in_shamt(sh), .in_mode(m), .in_tag(tg),
      .in_valid(v), .in_ready(rdy), .out_data(od), .out_tag(otg), .out_valid(ov), .out_ready(1'b1)
    );

    initial begin
      int   cy;
      exp_t e;
      rst = 1'b1; v = 1'b0; d = '0; sh = '0; m = '0; tg = '0; cy = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
        v  = i < 90 && $urandom_range(3) != 0;
        d  = W'({$urandom(), $urandom()});
        sh = SW'($urandom());
        m  = 2'($urandom());
        tg = 4'(i);
        #1;
        chk($sformatf("sw%0d_rdy", c), 64'(rdy), 64'(1));
        if (ov) begin
          if (q.size() == 0) chk($sformatf("sw%0d_stale", c), 64'(1), 64'(0));
          else begin
            e = q.pop_front();
            chk($sformatf("sw%0d_data", c), 64'(od), e.d);
            chk($sformatf("sw%0d_tag", c), 64'(otg), 64'(e.t));
            chk($sformatf("sw%0d_lat", c), 64'(cy - e.c), 64'(ST));
          end
        end
        if (v && rdy) begin
          e.d = ref_shift(64'(d), int'(sh), m, W);
          e.t = tg;
          e.c = cy;
          q.push_back(e);
        end
        cy++;
        @(negedge clk);
      end
      chk($sformatf("sw%0d_drain", c), 64'(q.size()), 64'(0));
      sw_done++;
    end
  end
endmodule

// File: doc/shift_pipelined_radix.md
SHIFT_PIPELINED_RADIX -- requirements
Module: shift_pipelined_radix

Interface
REQ-001 SHALL have parameter WIDTH, default 13, data width in bits (>=2).
REQ-002 SHALL have parameter RADIX_BITS, default 2, shift-amount bits resolved per pipeline stage (1..4).
REQ-003 SHALL have parameter TAG_W, default 4, width of the sideband tag passed through unchanged.
REQ-004 SHALL derive localparams SHAMT_W = max(1, clog2(WIDTH)) and STAGES = ceil(SHAMT_W/RADIX_BITS).
REQ-005 SHALL have port clk, input, 1: clock; all state on rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port in_data, input, WIDTH: operand.
REQ-008 SHALL have port in_shamt, input, SHAMT_W: shift amount.
REQ-009 SHALL have port in_mode, input, 2: 00 logical right, 01 logical left, 10 rotate right, 11 arithmetic right.
REQ-010 SHALL have port in_tag, input, TAG_W: sideband.
REQ-011 SHALL have ports in_valid (input, 1) and in_ready (output, 1): upstream handshake.
REQ-012 SHALL have ports out_data (output, WIDTH) and out_tag (output, TAG_W): result and tag.
REQ-013 SHALL have ports out_valid (output, 1) and out_ready (input, 1): downstream handshake.

Function
REQ-014 SHALL accept a transaction on a clock edge where in_valid && in_ready, and deliver it on an edge where out_valid && out_ready.
REQ-015 SHALL implement STAGES registered stages; stage s resolves shamt digit s (bits [s*RADIX_BITS +: RADIX_BITS], zero-extended past SHAMT_W), muxing among 2^RADIX_BITS displacements of digit*2^(s*RADIX_BITS).
REQ-016 SHALL carry shamt, mode and tag alongside the data in every stage.
REQ-017 SHALL have latency exactly STAGES cycles from acceptance to out_valid when out_ready is held high.
REQ-018 SHALL sustain throughput of one transaction per cycle when out_ready is held high.
REQ-019 SHALL advance each stage register only when it is empty or the next stage advances in the same cycle (bubble collapsing); in_ready = !valid[0] || advance[0], combinational from out_ready.
REQ-020 SHALL hold out_data, out_tag and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL never drop, duplicate or reorder transactions.
REQ-022 Logical right/left SHALL zero-fill; shamt >= WIDTH SHALL yield 0.
REQ-023 Arithmetic right SHALL fill with in_data[WIDTH-1]; shamt >= WIDTH SHALL yield all sign bits.
REQ-024 Rotate right SHALL give a result equal to rotation by (shamt mod WIDTH); each stage rotates by its displacement mod WIDTH.
REQ-025 shamt = 0 in any mode SHALL return in_data unchanged.

Reset
REQ-026 While reset is high, all stage valid bits SHALL clear at the clock edge, giving out_valid = 0 and in_ready = 1 after reset.
REQ-027 While reset is high, all data, shamt, mode and tag registers SHALL clear to 0, giving out_data = 0 and out_tag = 0.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight transactions; no transaction accepted while reset is high SHALL be delivered.

Verification (WIDTH=13, RADIX_BITS=2, STAGES=2, out_ready=1 unless stated)
REQ-029 in_data=13'h1001, shamt=3 in modes 00/01/10/11 -> out_data 13'h0200 / 13'h0008 / 13'h0600 / 13'h1E00, each 2 cycles after acceptance.
REQ-030 in_data=13'h1001, shamt=15 in modes 00/11/10 -> 13'h0000 / 13'h1FFF / 13'h0C00.
REQ-031 Back-to-back stream of 20 random transactions with tags 0..19 -> 20 results in order, one per cycle, matching a reference model, with tags intact.
REQ-032 out_ready low for 5 cycles during the stream -> out_data and out_tag stable while stalled; in_ready falls after the pipeline fills; no loss once out_ready returns high.
REQ-033 Reset pulsed with 2 transactions in flight -> out_valid = 0 the cycle after reset, and no stale result emerges afterwards.
REQ-034 Parameter sweep WIDTH in {2, 8, 13, 32, 64} by RADIX_BITS in {1, 2, 3} -> exhaustive or random shamt in all modes matches the model, with latency = STAGES.
